// File: rtl/lives_manager.sv
`default_nettype none
// ============================================================================
//  Module      : lives_manager
//  Description : Player life counter with post-hit invulnerability window,
//                sprite blink generation and life-lost event pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module lives_manager #(
    parameter int START_LIVES  = 3,
    parameter int MAX_LIVES    = 3,
    parameter int INVULN_TICKS = 90,
    parameter int BLINK_TICKS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_start,
    input  logic       hit,
    input  logic       heal,
    input  logic       tick,
    output logic [3:0] lives,
    output logic       invincible,
    output logic       blink,
    output logic       life_lost
);

    localparam int INV_W = (INVULN_TICKS < 2) ? 1 : $clog2(INVULN_TICKS + 1);
    localparam int BLK_W = (BLINK_TICKS  < 2) ? 1 : $clog2(BLINK_TICKS + 1);

    localparam logic [3:0]       c_start_lives = 4'(START_LIVES);
    localparam logic [3:0]       c_max_lives   = 4'(MAX_LIVES);
    localparam logic [INV_W-1:0] c_inv_load    = INV_W'(INVULN_TICKS);
    localparam logic [INV_W-1:0] c_inv_one     = INV_W'(1);
    localparam logic [BLK_W-1:0] c_blink_last  = BLK_W'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ALIVE  = 2'd1,
        S_INVULN = 2'd2,
        S_DEAD   = 2'd3
    } state_t;

    state_t           r_state;
    logic [3:0]       r_lives;
    logic [INV_W-1:0] r_inv_cnt;
    logic [BLK_W-1:0] r_blink_cnt;
    logic             r_blink;
    logic             r_invincible;
    logic             r_life_lost;

    state_t           w_state_nxt;
    logic [3:0]       w_lives_nxt;
    logic [INV_W-1:0] w_inv_cnt_nxt;
    logic [BLK_W-1:0] w_blink_cnt_nxt;
    logic             w_blink_nxt;
    logic             w_life_lost_nxt;
    logic [3:0]       w_lives_healed;
    logic [3:0]       w_lives_hit;

    // Saturating arithmetic keeps lives inside [0, MAX_LIVES] in every state.
    assign w_lives_healed = (r_lives >= c_max_lives) ? c_max_lives : r_lives + 4'd1;
    assign w_lives_hit    = (r_lives == 4'd0) ? 4'd0 : r_lives - 4'd1;

    always_comb begin
        w_state_nxt     = r_state;
        w_lives_nxt     = r_lives;
        w_inv_cnt_nxt   = r_inv_cnt;
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_nxt     = r_blink;
        w_life_lost_nxt = 1'b0;

        if (game_start) begin
            w_state_nxt     = S_ALIVE;
            w_lives_nxt     = c_start_lives;
            w_inv_cnt_nxt   = '0;
            w_blink_cnt_nxt = '0;
            w_blink_nxt     = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_lives_nxt = c_start_lives;
                end
                S_ALIVE: begin
                    if (hit) begin
                        w_lives_nxt     = w_lives_hit;
                        w_life_lost_nxt = 1'b1;
                        w_blink_cnt_nxt = '0;
                        w_blink_nxt     = 1'b0;
                        if (w_lives_hit == 4'd0) begin
                            w_state_nxt   = S_DEAD;
                            w_inv_cnt_nxt = '0;
                        end else begin
                            w_state_nxt   = S_INVULN;
                            w_inv_cnt_nxt = c_inv_load;
                        end
                    end else if (heal) begin
                        w_lives_nxt = w_lives_healed;
                    end
                end
                S_INVULN: begin
                    // A pending hit still outranks heal even though it is ignored here.
                    if (heal && !hit) begin
                        w_lives_nxt = w_lives_healed;
                    end
                    if (tick) begin
                        if (r_inv_cnt <= c_inv_one) begin
                            w_state_nxt     = S_ALIVE;
                            w_inv_cnt_nxt   = '0;
                            w_blink_cnt_nxt = '0;
                            w_blink_nxt     = 1'b0;
                        end else begin
                            w_inv_cnt_nxt = r_inv_cnt - c_inv_one;
                            if (r_blink_cnt >= c_blink_last) begin
                                w_blink_cnt_nxt = '0;
                                w_blink_nxt     = ~r_blink;
                            end else begin
                                w_blink_cnt_nxt = r_blink_cnt + BLK_W'(1);
                            end
                        end
                    end
                end
                S_DEAD: begin
                    w_lives_nxt = 4'd0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_lives_nxt = c_start_lives;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lives      <= c_start_lives;
            r_inv_cnt    <= '0;
            r_blink_cnt  <= '0;
            r_blink      <= 1'b0;
            r_invincible <= 1'b0;
            r_life_lost  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lives      <= w_lives_nxt;
            r_inv_cnt    <= w_inv_cnt_nxt;
            r_blink_cnt  <= w_blink_cnt_nxt;
            r_blink      <= w_blink_nxt;
            r_invincible <= (w_state_nxt == S_INVULN);
            r_life_lost  <= w_life_lost_nxt;
        end
    end

    assign lives      = r_lives;
    assign invincible = r_invincible;
    assign blink      = r_blink;
    assign life_lost  = r_life_lost;

endmodule
`default_nettype wire

// File: tb/tb_lives_manager.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lives_manager
//  Description : Self-checking bench for lives_manager (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lives_manager;

    logic       clk;
    logic       rst;
    logic       game_start;
    logic       hit;
    logic       heal;
    logic       tick;
    logic [3:0] lives;
    logic       invincible;
    logic       blink;
    logic       life_lost;

    int n_tests;
    int n_fail;

    lives_manager #(
        .START_LIVES (3),
        .MAX_LIVES   (3),
        .INVULN_TICKS(90),
        .BLINK_TICKS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .game_start (game_start),
        .hit        (hit),
        .heal       (heal),
        .tick       (tick),
        .lives      (lives),
        .invincible (invincible),
        .blink      (blink),
        .life_lost  (life_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       gs;
        logic       hit;
        logic       heal;
        logic       tick;
        logic [3:0] exp_lives;
        logic       exp_inv;
        logic       exp_blink;
        logic       exp_ll;
    } vec_t;

    vec_t vecs[14];

    // Drive one cycle of inputs, let the edge happen, and return 1 ns after it.
    task automatic cyc(input logic r, input logic g, input logic h, input logic e, input logic t);
        rst = r; game_start = g; hit = h; heal = e; tick = t;
        @(posedge clk);
        #1;
        rst = 1'b0; game_start = 1'b0; hit = 1'b0; heal = 1'b0; tick = 1'b0;
    endtask

    task automatic chk(input string name, input logic [3:0] el, input logic ei,
                       input logic eb, input logic ell);
        n_tests++;
        if (lives !== el || invincible !== ei || blink !== eb || life_lost !== ell) begin
            n_fail++;
            $display("FAIL %s: got lives=%0d inv=%b blink=%b ll=%b, expected lives=%0d inv=%b blink=%b ll=%b",
                     name, lives, invincible, blink, life_lost, el, ei, eb, ell);
        end
    endtask

    // Run out an invulnerability window and confirm the return to ALIVE.
    task automatic expire(input logic [3:0] el);
        for (int k = 0; k < 90; k++) cyc(0, 0, 0, 0, 1);
        chk("expire", el, 1'b0, 1'b0, 1'b0);
    endtask

    int   toggles;
    logic prev_blink;
    logic exp_b;

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b0; game_start = 1'b0; hit = 1'b0; heal = 1'b0; tick = 1'b0;
        @(posedge clk); #1;

        //           rst gs hit heal tick  lives inv blk ll
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0}; // reset
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0}; // hit in IDLE
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0}; // heal/tick in IDLE
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0}; // start
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0}; // heal at max
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1}; // hit 3->2
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0}; // pulse ends
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0}; // hit ignored
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0}; // one tick
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0}; // start beats hit
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 1'b1}; // hit beats heal
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0}; // rst mid-INVULN
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0}; // hit back in IDLE
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0}; // start again

        for (int i = 0; i < 14; i++) begin
            cyc(vecs[i].rst, vecs[i].gs, vecs[i].hit, vecs[i].heal, vecs[i].tick);
            chk($sformatf("vec%0d", i), vecs[i].exp_lives, vecs[i].exp_inv,
                vecs[i].exp_blink, vecs[i].exp_ll);
        end

        // Full invulnerability window: periodic hits, blink cadence, hit on expiry tick.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("inv_entry", 4'd2, 1'b1, 1'b0, 1'b1);
        toggles = 0;
        prev_blink = blink;
        for (int k = 1; k <= 90; k++) begin
            if (k % 5 == 0) begin
                cyc(0, 0, 1, 0, 0);
                chk($sformatf("inv_hit%0d", k), 4'd2, 1'b1, prev_blink, 1'b0);
            end
            if (k == 90) cyc(0, 0, 1, 0, 1);
            else         cyc(0, 0, 0, 0, 1);
            exp_b = (k < 90) ? logic'((k / 8) % 2) : 1'b0;
            chk($sformatf("inv_tick%0d", k), 4'd2, (k < 90), exp_b, 1'b0);
            if (k < 90 && blink !== prev_blink) toggles++;
            prev_blink = blink;
        end
        n_tests++;
        if (toggles != 11) begin
            n_fail++;
            $display("FAIL blink_toggles: got %0d, expected 11", toggles);
        end

        // Heal behaviour and start/hit collision at one life.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        expire(4'd2);
        cyc(0, 0, 1, 0, 0);
        chk("hit_2to1", 4'd1, 1'b1, 1'b0, 1'b1);
        expire(4'd1);
        cyc(0, 0, 0, 1, 0);
        chk("heal_1to2", 4'd2, 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 1, 1, 0);
        chk("hit_heal_2", 4'd1, 1'b1, 1'b0, 1'b1);
        expire(4'd1);
        cyc(0, 1, 1, 0, 0);
        chk("start_hit_1", 4'd3, 1'b0, 1'b0, 1'b0);

        // Down to DEAD and back.
        cyc(0, 0, 1, 0, 0);
        expire(4'd2);
        cyc(0, 0, 1, 0, 0);
        expire(4'd1);
        cyc(0, 0, 1, 0, 0);
        chk("hit_to_dead", 4'd0, 1'b0, 1'b0, 1'b1);
        cyc(0, 0, 1, 0, 0);
        chk("dead_hit", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 0, 1, 1);
        chk("dead_heal", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(0, 1, 0, 0, 0);
        chk("dead_start", 4'd3, 1'b0, 1'b0, 1'b0);

        // Reset from DEAD lands in IDLE with start lives.
        cyc(0, 0, 1, 0, 0);
        expire(4'd2);
        cyc(0, 0, 1, 0, 0);
        expire(4'd1);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("dead_rst", 4'd3, 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 1, 0, 0);
        chk("idle_hit", 4'd3, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
